// File: rtl/vpg_mode_if.sv
// Mode-apply handshake bundle: mode requests in, PLL request/lock handshake,
// timing-generator load and status out.
interface vpg_mode_if;
  logic       vpg_mode_change;
  logic [3:0] vpg_mode;
  logic       pll_req;
  logic [3:0] pll_mode;
  logic       pll_ack;
  logic       pll_locked;
  logic       timing_load;
  logic [3:0] active_mode;
  logic       video_blank;
  logic       ready;
  logic       lock_err;

  modport master (
    output vpg_mode_change, vpg_mode, pll_ack, pll_locked,
    input  pll_req, pll_mode, timing_load, active_mode, video_blank, ready, lock_err
  );

  modport slave (
    input  vpg_mode_change, vpg_mode, pll_ack, pll_locked,
    output pll_req, pll_mode, timing_load, active_mode, video_blank, ready, lock_err
  );
endinterface

// File: rtl/vpg_mode_apply.sv
// Video mode apply sequencer: blank video, reprogram the pixel PLL, wait for a
// stable lock, then pulse the timing generator to load the new mode.
module vpg_mode_apply #(
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned LOCK_STABLE  = 8,
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned MAX_MODE     = 9,
  parameter int unsigned RESET_MODE   = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  vpg_mode_if.slave   bus
);

  typedef enum logic [2:0] {S_IDLE, S_BLANK, S_REQ, S_WAIT_LOCK, S_LOAD} state_t;

  localparam logic [15:0] BLANK_LAST   = 16'(BLANK_CYCLES - 1);
  localparam logic [15:0] STABLE_LAST  = 16'(LOCK_STABLE - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
  localparam logic [3:0]  RESET_CODE   = 4'(RESET_MODE);

  state_t      r_state;
  logic [15:0] r_blank_cnt;
  logic [15:0] r_stable_cnt;
  logic [15:0] r_timeout_cnt;
  logic        r_pend_valid;
  logic [3:0]  r_pend_mode;
  logic        r_pll_req;
  logic [3:0]  r_pll_mode;
  logic        r_timing_load;
  logic [3:0]  r_active_mode;
  logic        r_video_blank;
  logic        r_ready;
  logic        r_lock_err;

  logic w_legal;
  assign w_legal = bus.vpg_mode_change && ({28'd0, bus.vpg_mode} <= MAX_MODE);

  assign bus.pll_req     = r_pll_req;
  assign bus.pll_mode    = r_pll_mode;
  assign bus.timing_load = r_timing_load;
  assign bus.active_mode = r_active_mode;
  assign bus.video_blank = r_video_blank;
  assign bus.ready       = r_ready;
  assign bus.lock_err    = r_lock_err;

  // Reset lands directly in BLANK so the reset mode is applied without a request.
  // NOTE: every register here is a control/state flop with a defined reset value;
  // there is no storage array, so nothing is left unreset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_BLANK;
      r_blank_cnt   <= '0;
      r_stable_cnt  <= '0;
      r_timeout_cnt <= '0;
      r_pend_valid  <= 1'b0;
      r_pend_mode   <= '0;
      r_pll_req     <= 1'b0;
      r_pll_mode    <= RESET_CODE;
      r_timing_load <= 1'b0;
      r_active_mode <= RESET_CODE;
      r_video_blank <= 1'b1;
      r_ready       <= 1'b0;
      r_lock_err    <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout; this default is overridden by the later
      // assignment on entry to LOAD, giving a single-cycle pulse.
      r_timing_load <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_legal) begin
            r_pll_mode    <= bus.vpg_mode;
            r_blank_cnt   <= '0;
            r_video_blank <= 1'b1;
            r_ready       <= 1'b0;
            r_state       <= S_BLANK;
          end
        end
        S_BLANK: begin
          if (w_legal) begin
            r_pll_mode  <= bus.vpg_mode;
            r_blank_cnt <= '0;
          end else if (r_blank_cnt == BLANK_LAST) begin
            r_pll_req <= 1'b1;
            r_state   <= S_REQ;
          end else begin
            r_blank_cnt <= r_blank_cnt + 16'd1;
          end
        end
        S_REQ: begin
          if (w_legal) begin
            r_pend_valid <= 1'b1;
            r_pend_mode  <= bus.vpg_mode;
          end
          if (bus.pll_ack) begin
            r_pll_req     <= 1'b0;
            r_stable_cnt  <= '0;
            r_timeout_cnt <= '0;
            r_state       <= S_WAIT_LOCK;
          end
        end
        S_WAIT_LOCK: begin
          if (w_legal) begin
            r_pend_valid <= 1'b1;
            r_pend_mode  <= bus.vpg_mode;
          end
          // Lock acceptance takes priority over a timeout in the same cycle.
          if (bus.pll_locked && (r_stable_cnt == STABLE_LAST)) begin
            r_active_mode <= r_pll_mode;
            r_timing_load <= 1'b1;
            r_lock_err    <= 1'b0;
            r_state       <= S_LOAD;
          end else if (r_timeout_cnt == TIMEOUT_LAST) begin
            r_lock_err <= 1'b1;
            r_pll_req  <= 1'b1;
            r_state    <= S_REQ;
          end else begin
            r_timeout_cnt <= r_timeout_cnt + 16'd1;
            r_stable_cnt  <= bus.pll_locked ? r_stable_cnt + 16'd1 : '0;
          end
        end
        S_LOAD: begin
          // A request arriving in this very cycle is the latest and wins.
          if (w_legal || r_pend_valid) begin
            r_pll_mode   <= w_legal ? bus.vpg_mode : r_pend_mode;
            r_pend_valid <= 1'b0;
            r_blank_cnt  <= '0;
            r_state      <= S_BLANK;
          end else begin
            r_video_blank <= 1'b0;
            r_ready       <= 1'b1;
            r_state       <= S_IDLE;
          end
        end
        default: begin
          r_pll_req     <= 1'b0;
          r_video_blank <= 1'b1;
          r_ready       <= 1'b0;
          r_state       <= S_BLANK;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vpg_mode_apply.sv
// Self-checking bench for vpg_mode_apply: phase-level reference model compared
// every cycle, directed scenarios with literal timing pins, then random traffic.
module tb_vpg_mode_apply;

  localparam int BLANK_CYCLES = 16;
  localparam int LOCK_STABLE  = 8;
  localparam int LOCK_TIMEOUT = 100;
  localparam int MAX_MODE     = 9;
  localparam int RESET_MODE   = 0;

  localparam int P_IDLE = 0, P_BLANK = 1, P_REQ = 2, P_WAIT = 3, P_LOAD = 4;

  // {pll_req, pll_mode, timing_load, active_mode, video_blank, ready, lock_err}
  localparam logic [12:0] RESET_VEC = 13'b0_0000_0_0000_1_0_0;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  vpg_mode_if bus ();

  vpg_mode_apply #(
    .BLANK_CYCLES (BLANK_CYCLES),
    .LOCK_STABLE  (LOCK_STABLE),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .MAX_MODE     (MAX_MODE),
    .RESET_MODE   (RESET_MODE)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  // Reference model: phase plus remaining/elapsed cycle counts and a request log.
  int m_phase, m_blank_left, m_waited, m_run, m_target, m_active;
  bit m_err;
  int m_pend_q[$];

  // Stimulus knobs and observations of timing_load pulses.
  int ack_delay = 3;
  int req_age = 0;
  int lock_policy = 1;
  bit noise_en = 1'b0;
  int tl_modes[$];
  int tl_errs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase      = P_BLANK;
    m_blank_left = BLANK_CYCLES;
    m_target     = RESET_MODE;
    m_active     = RESET_MODE;
    m_err        = 1'b0;
    m_waited     = 0;
    m_run        = 0;
    m_pend_q.delete();
  endtask

  task automatic model_step(input bit chg, input int mode, input bit ack, input bit locked);
    bit legal;
    legal = chg && (mode <= MAX_MODE);
    case (m_phase)
      P_IDLE: if (legal) begin
        m_target     = mode;
        m_phase      = P_BLANK;
        m_blank_left = BLANK_CYCLES;
      end
      P_BLANK: if (legal) begin
        m_target     = mode;
        m_blank_left = BLANK_CYCLES;
      end else begin
        m_blank_left--;
        if (m_blank_left == 0) m_phase = P_REQ;
      end
      P_REQ: begin
        if (legal) m_pend_q.push_back(mode);
        if (ack) begin
          m_phase  = P_WAIT;
          m_waited = 0;
          m_run    = 0;
        end
      end
      P_WAIT: begin
        if (legal) m_pend_q.push_back(mode);
        m_waited++;
        m_run = locked ? m_run + 1 : 0;
        if (m_run >= LOCK_STABLE) begin
          m_phase  = P_LOAD;
          m_active = m_target;
          m_err    = 1'b0;
        end else if (m_waited >= LOCK_TIMEOUT) begin
          m_err   = 1'b1;
          m_phase = P_REQ;
        end
      end
      default: begin
        if (legal) m_pend_q.push_back(mode);
        if (m_pend_q.size() > 0) begin
          m_target     = m_pend_q[$];
          m_pend_q.delete();
          m_phase      = P_BLANK;
          m_blank_left = BLANK_CYCLES;
        end else begin
          m_phase = P_IDLE;
        end
      end
    endcase
  endtask

  function automatic logic [12:0] model_outs();
    return {m_phase == P_REQ, 4'(m_target), m_phase == P_LOAD, 4'(m_active),
            m_phase != P_IDLE, m_phase == P_IDLE, m_err};
  endfunction

  function automatic logic [12:0] dut_outs();
    return {bus.pll_req, bus.pll_mode, bus.timing_load, bus.active_mode,
            bus.video_blank, bus.ready, bus.lock_err};
  endfunction

  always @(negedge clk) begin
    if (cmp_en) check("cycle_outs", 32'(dut_outs()), 32'(model_outs()));
  end

  // One clock cycle: drive inputs, let the DUT and model advance, land on negedge.
  task automatic step(input bit chg, input logic [3:0] mode);
    bit ack, lk;
    if (m_phase == P_REQ) begin
      ack = (req_age >= ack_delay);
      req_age++;
    end else begin
      ack = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
      req_age = 0;
    end
    case (lock_policy)
      0:       lk = 1'b0;
      1:       lk = 1'b1;
      default: lk = ($urandom_range(0, 9) < 8);
    endcase
    bus.vpg_mode_change = chg;
    bus.vpg_mode        = chg ? mode : 4'($urandom_range(0, 15));
    bus.pll_ack         = ack;
    bus.pll_locked      = lk;
    @(posedge clk);
    model_step(chg, int'(mode), ack, lk);
    @(negedge clk);
    if (bus.timing_load) begin
      tl_modes.push_back(int'(bus.active_mode));
      tl_errs.push_back(int'(bus.lock_err));
    end
  endtask

  task automatic do_reset();
    #1;
    reset_n = 1'b0;
    model_reset();
    req_age = 0;
    bus.vpg_mode_change = 1'b0;
    bus.vpg_mode        = '0;
    bus.pll_ack         = 1'b0;
    bus.pll_locked      = 1'b0;
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outs", 32'(dut_outs()), 32'(RESET_VEC));
    #1;
    reset_n = 1'b1;
  endtask

  task automatic run_until_ready(input int max_cyc, output int n);
    n = 0;
    while (!bus.ready && n < max_cyc) begin
      step(1'b0, 4'd0);
      n++;
    end
    check("ready_reached", 32'(bus.ready), 32'd1);
  endtask

  task automatic wait_pll_req(input bit level, input int max_cyc, output int n);
    n = 0;
    while (bus.pll_req !== level && n < max_cyc) begin
      step(1'b0, 4'd0);
      n++;
    end
    check("pll_req_level", 32'(bus.pll_req), 32'(level));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n2, base;

    // Boot: reset mode applied without any request.
    do_reset();
    wait_pll_req(1'b1, 100, n);
    check("boot_first_req_cycle", 32'(n + 1), 32'd17);
    base = tl_modes.size();
    run_until_ready(200, n2);
    check("boot_ready_cycle", 32'(n + n2 + 1), 32'd30);
    check("boot_load_count", 32'(tl_modes.size() - base), 32'd1);
    check("boot_active", 32'(bus.active_mode), 32'd0);

    // Simple apply of mode 5 from IDLE.
    base = tl_modes.size();
    step(1'b1, 4'd5);
    check("m5_blank", 32'(bus.video_blank), 32'd1);
    check("m5_pll_mode", 32'(bus.pll_mode), 32'd5);
    check("m5_ready_low", 32'(bus.ready), 32'd0);
    run_until_ready(200, n);
    check("m5_load_count", 32'(tl_modes.size() - base), 32'd1);
    check("m5_active", 32'(bus.active_mode), 32'd5);

    // Mode 3 replaced by mode 7 at blank cycle 10: the count restarts.
    base = tl_modes.size();
    step(1'b1, 4'd3);
    repeat (9) step(1'b0, 4'd0);
    step(1'b1, 4'd7);
    check("m7_pll_mode", 32'(bus.pll_mode), 32'd7);
    wait_pll_req(1'b1, 100, n);
    check("m7_blank_restart", 32'(n), 32'd16);
    run_until_ready(200, n);
    check("m7_load_count", 32'(tl_modes.size() - base), 32'd1);
    check("m7_loaded_mode", 32'(tl_modes[base]), 32'd7);

    // Mode 4 requested while mode 2 waits for lock: two loads, no IDLE between.
    base = tl_modes.size();
    step(1'b1, 4'd2);
    wait_pll_req(1'b1, 100, n);
    wait_pll_req(1'b0, 100, n);
    step(1'b1, 4'd4);
    check("m24_pll_mode_held", 32'(bus.pll_mode), 32'd2);
    run_until_ready(300, n);
    check("m24_load_count", 32'(tl_modes.size() - base), 32'd2);
    check("m24_first_mode", 32'(tl_modes[base]), 32'd2);
    check("m24_second_mode", 32'(tl_modes[base + 1]), 32'd4);

    // Lock timeout with pll_locked low, then recovery.
    lock_policy = 0;
    base = tl_modes.size();
    step(1'b1, 4'd1);
    wait_pll_req(1'b1, 100, n);
    wait_pll_req(1'b0, 100, n);
    n2 = 0;
    while (!bus.lock_err && n2 < 300) begin
      step(1'b0, 4'd0);
      n2++;
    end
    check("timeout_cycles", 32'(n2), 32'(LOCK_TIMEOUT));
    check("timeout_err", 32'(bus.lock_err), 32'd1);
    check("timeout_req_again", 32'(bus.pll_req), 32'd1);
    lock_policy = 1;
    run_until_ready(300, n);
    check("timeout_load_count", 32'(tl_modes.size() - base), 32'd1);
    check("timeout_err_at_load", 32'(tl_errs[base]), 32'd0);
    check("timeout_active", 32'(bus.active_mode), 32'd1);

    // Illegal code in IDLE is ignored.
    step(1'b1, 4'd12);
    check("illegal_ready", 32'(bus.ready), 32'd1);
    check("illegal_blank", 32'(bus.video_blank), 32'd0);
    check("illegal_pll_mode", 32'(bus.pll_mode), 32'd1);

    // Reset mid-sequence: no load pulse, then the boot sequence runs again.
    base = tl_modes.size();
    step(1'b1, 4'd6);
    wait_pll_req(1'b1, 100, n);
    wait_pll_req(1'b0, 100, n);
    step(1'b0, 4'd0);
    do_reset();
    check("abort_no_load", 32'(tl_modes.size() - base), 32'd0);
    run_until_ready(200, n);
    check("abort_boot_active", 32'(bus.active_mode), 32'(RESET_MODE));

    // Random traffic: pulses with any code, ack/lock noise, occasional reset.
    noise_en    = 1'b1;
    lock_policy = 2;
    for (int i = 0; i < 2500; i++) begin
      if (m_phase != P_REQ) ack_delay = $urandom_range(0, 4);
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 11) == 0, 4'($urandom_range(0, 15)));
      end
    end
    noise_en    = 1'b0;
    lock_policy = 1;
    run_until_ready(1000, n);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vpg_mode_apply.md
VPG_MODE_APPLY -- requirements
Module: vpg_mode_apply

Interface
REQ-001 Parameter BLANK_CYCLES, default 16: cycles video stays blanked before the PLL request.
REQ-002 Parameter LOCK_STABLE, default 8: consecutive pll_locked-high cycles required to accept lock.
REQ-003 Parameter LOCK_TIMEOUT, default 65535: WAIT_LOCK cycles allowed before the request is retried.
REQ-004 Parameter MAX_MODE, default 9: highest legal mode code.
REQ-005 Parameter RESET_MODE, default 0: mode applied automatically after reset.
REQ-006 clk  input  1  single clock for all logic.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 vpg_mode_change  input  1  one-cycle pulse: new mode requested.
REQ-009 vpg_mode  input  4  requested mode code, valid while vpg_mode_change is high.
REQ-010 pll_req  output  1  PLL reconfiguration request, level.
REQ-011 pll_mode  output  4  mode code presented to the PLL, stable while pll_req is high.
REQ-012 pll_ack  input  1  PLL accepted the request.
REQ-013 pll_locked  input  1  pixel PLL lock indicator.
REQ-014 timing_load  output  1  one-cycle pulse: timing generator loads parameters for active_mode.
REQ-015 active_mode  output  4  mode currently applied.
REQ-016 video_blank  output  1  high forces video output blank.
REQ-017 ready  output  1  high only in IDLE.
REQ-018 lock_err  output  1  sticky lock-timeout flag.

Function
REQ-019 FSM states SHALL be IDLE, BLANK, REQ, WAIT_LOCK, LOAD.
REQ-020 IDLE: on vpg_mode_change with vpg_mode <= MAX_MODE, latch target into pll_mode and go to BLANK next cycle; codes > MAX_MODE SHALL be ignored with no state or output change.
REQ-021 video_blank SHALL assert in the same cycle the FSM leaves IDLE and stay high in all non-IDLE states.
REQ-022 BLANK: count BLANK_CYCLES cycles, then REQ; a legal vpg_mode_change in BLANK SHALL replace pll_mode and restart the count from zero.
REQ-023 REQ: pll_req high; on pll_ack high, pll_req SHALL drop the next cycle and the FSM SHALL enter WAIT_LOCK.
REQ-024 WAIT_LOCK: a 16-bit stable counter increments while pll_locked is high and clears when it is low; reaching LOCK_STABLE moves to LOAD.
REQ-025 WAIT_LOCK: after LOCK_TIMEOUT cycles without acceptance, set lock_err and return to REQ; the timeout counter SHALL clear on each entry to WAIT_LOCK.
REQ-026 LOAD: active_mode <= pll_mode, timing_load high for exactly this one cycle, and lock_err cleared.
REQ-027 A legal vpg_mode_change during REQ, WAIT_LOCK or LOAD SHALL be stored as pending, with the latest code winning; pll_mode SHALL NOT change until the current sequence leaves LOAD.
REQ-028 After LOAD: with pending set, load the pending code into pll_mode, clear pending and go to BLANK, keeping video_blank high; otherwise go to IDLE, with video_blank low and ready high from that cycle.
REQ-029 pll_ack outside REQ SHALL be ignored; pll_locked dropping in IDLE SHALL NOT start a sequence.

Reset
REQ-030 Asynchronous reset SHALL force pll_req=0, timing_load=0, lock_err=0, ready=0, video_blank=1, active_mode=RESET_MODE, pll_mode=RESET_MODE, pending cleared, all counters zero.
REQ-031 On release, the FSM SHALL enter BLANK with target RESET_MODE, so a full apply sequence runs without any vpg_mode_change.
REQ-032 Reset asserted mid-sequence SHALL abort immediately with no timing_load pulse; outputs take REQ-030 values.

Verification
REQ-033 Reset release, pll_ack after 3 cycles, pll_locked held high -> pll_req high 17 cycles after release; one timing_load; active_mode=0; ready high at cycle 17+4+8+1.
REQ-034 In IDLE, pulse with mode 5 -> video_blank high same cycle; pll_mode=5; timing_load once; active_mode=5; ready returns high.
REQ-035 Pulse mode 3, then mode 7 at BLANK cycle 10 -> blank count restarts; pll_mode=7; only mode 7 applied; one timing_load.
REQ-036 Pulse mode 2, then mode 4 during WAIT_LOCK -> mode 2 loaded; video_blank stays high; second sequence applies mode 4; two timing_load pulses; ready only after the second.
REQ-037 pll_locked held low with LOCK_TIMEOUT=100 -> lock_err set at timeout; pll_req reasserted; after lock, lock_err clears in LOAD.
REQ-038 Pulse mode 12 in IDLE -> no output change; ready stays high.
